// File: rtl/picosoc_regfile_mp.sv
// picosoc_regfile_mp: single-write, multi-read register file with registered
// read ports and a post-reset clear sequencer that zeroes the array (the
// array itself has no reset so it can map onto synchronous SRAM).
// Optional feature: define PICOSOC_REGFILE_BYPASS_EN for write-first reads on
// a same-cycle read/write collision; undefined gives read-first behaviour.
module picosoc_regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wen,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [NRD-1:0]        ren,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   output logic                  busy
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      READY = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_next;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // busy is the state bit itself, so it comes straight from a flop
   assign busy = (state == CLEAR);

   // Sequencer state and clear counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state: walk the counter through every entry, then go READY
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      if (state == CLEAR) begin
         cnt_next = cnt + 1'b1;
         if (cnt == ADDR_W'(DEPTH - 1)) begin
            state_next = READY;
         end
      end
   end

   // Single array write port, shared between the clear sequencer and wen
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = waddr;
      mem_wdata = wdata;
      if (state == CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = cnt;
         mem_wdata = '0;
      end else begin
         mem_we = wen && !((ZERO_REG != 0) && (waddr == '0));
      end
   end

   // Array storage, deliberately without reset
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_next;
      logic [DATA_W-1:0] rd_p1;

      assign ra = raddr[p*ADDR_W +: ADDR_W];

      // Read value selection: array, optional write-through, zero register
      always_comb begin
         rd_next = mem[ra];
`ifdef PICOSOC_REGFILE_BYPASS_EN
         if (wen && (waddr == ra)) begin
            rd_next = wdata;
         end
`endif
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rd_next = '0;
         end
      end

      // Registered read port: zero while clearing, hold when ren is low
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            rd_p1 <= '0;
         end else if (state == CLEAR) begin
            rd_p1 <= '0;
         end else if (ren[p]) begin
            rd_p1 <= rd_next;
         end
      end

      assign rdata[p*DATA_W +: DATA_W] = rd_p1;
   end

endmodule

// File: tb/tb_picosoc_regfile_mp.sv
// Directed bench for picosoc_regfile_mp: one instance with ZERO_REG=1 and one
// with ZERO_REG=0 share the same stimulus.
module tb_picosoc_regfile_mp;

   logic        clk = 1'b0;
   logic        reset;
   logic        wen;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [1:0]  ren;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        busy;
   logic [63:0] rdata_z;
   logic        busy_z;

   int total = 0;
   int bad   = 0;
   int n;

   picosoc_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) dut (
      .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rdata(rdata), .busy(busy)
   );

   picosoc_regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(0)) dutz (
      .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
      .ren(ren), .raddr(raddr), .rdata(rdata_z), .busy(busy_z)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] coll_exp;
      reset = 1'b1;
      wen   = 1'b0;
      waddr = '0;
      wdata = '0;
      ren   = '0;
      raddr = '0;
      #1;
      chk("reset_busy", {63'd0, busy}, 64'd1);
      chk("reset_rdata", rdata, 64'd0);
      tick();
      tick();
      reset = 1'b0;

      // Clear sequence length
      n = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         n++;
         if (!busy) break;
      end
      chk("clear_edges", 64'(n), 64'd32);
      chk("clear_edges_z", {63'd0, busy_z}, 64'd0);

      // Every entry reads zero after the clear
      ren = 2'b11;
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(31 - a), 5'(a)};
         tick();
         chk("clear_read", rdata, 64'd0);
         chk("clear_read_z", rdata_z, 64'd0);
      end
      ren = 2'b00;

      // Basic write then read
      wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
      tick();
      wen = 1'b0; ren = 2'b11; raddr = {5'd6, 5'd5};
      tick();
      chk("basic_p0", {32'd0, rdata[31:0]}, 64'h0000_0000_DEAD_BEEF);
      chk("basic_p1", {32'd0, rdata[63:32]}, 64'd0);

      // Zero register
      ren = 2'b00; wen = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
      tick();
      wen = 1'b0; ren = 2'b11; raddr = {5'd0, 5'd0};
      tick();
      chk("zero_reg1", rdata, 64'd0);
      chk("zero_reg0", rdata_z, 64'h1234_5678_1234_5678);

      // Same-cycle collision on entry 7
      ren = 2'b00; wen = 1'b1; waddr = 5'd7; wdata = 32'h11;
      tick();
      wen = 1'b1; waddr = 5'd7; wdata = 32'h22; ren = 2'b01; raddr = {5'd0, 5'd7};
      tick();
`ifdef PICOSOC_REGFILE_BYPASS_EN
      coll_exp = 32'h22;
`else
      coll_exp = 32'h11;
`endif
      chk("collision", {32'd0, rdata[31:0]}, {32'd0, coll_exp});
      wen = 1'b0;
      tick();
      chk("collision_next", {32'd0, rdata[31:0]}, 64'h22);

      // Read hold with ren low while the entry changes
      ren = 2'b00; wen = 1'b1; waddr = 5'd3; wdata = 32'hA5;
      tick();
      wen = 1'b0; ren = 2'b01; raddr = {5'd0, 5'd3};
      tick();
      chk("hold_first", {32'd0, rdata[31:0]}, 64'hA5);
      ren = 2'b00; wen = 1'b1; waddr = 5'd3; wdata = 32'h5A;
      tick();
      chk("hold_c1", {32'd0, rdata[31:0]}, 64'hA5);
      wen = 1'b0;
      tick();
      chk("hold_c2", {32'd0, rdata[31:0]}, 64'hA5);
      tick();
      chk("hold_c3", {32'd0, rdata[31:0]}, 64'hA5);
      ren = 2'b01;
      tick();
      chk("hold_release", {32'd0, rdata[31:0]}, 64'h5A);

      // Fill every entry with a nonzero value
      ren = 2'b00;
      for (int a = 0; a < 32; a++) begin
         wen = 1'b1; waddr = 5'(a); wdata = 32'(a + 1) | 32'hC000_0000;
         tick();
      end
      wen = 1'b0; ren = 2'b11; raddr = {5'd20, 5'd10};
      tick();
      chk("fill_p0", {32'd0, rdata[31:0]}, 64'hC000_000B);
      chk("fill_z", rdata_z, 64'hC000_0015_C000_000B);

      // Asynchronous reset between edges
      #3;
      reset = 1'b1;
      #1;
      chk("async_busy", {63'd0, busy}, 64'd1);
      chk("async_rdata", rdata, 64'd0);
      chk("async_rdata_z", rdata_z, 64'd0);
      #2;
      reset = 1'b0;

      // Writes and reads attempted throughout the clear
      n = 0;
      for (int i = 0; i < 100; i++) begin
         wen = 1'b1; waddr = 5'(31 - (i % 32)); wdata = 32'hFFFF_FFFF;
         ren = 2'b11; raddr = {5'd9, 5'd4};
         tick();
         n++;
         if (!busy) break;
         chk("clear_rdata_zero", rdata_z, 64'd0);
      end
      wen = 1'b0;
      chk("reclear_edges", 64'(n), 64'd32);

      ren = 2'b11;
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(a), 5'(31 - a)};
         tick();
         chk("reclear_read", rdata, 64'd0);
         chk("reclear_read_z", rdata_z, 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
